// File: rtl/inst_loader.sv
// Program loader: packs 16-bit stream halfwords into a 16x32 instruction store and holds the
// processor until the load completes. Optional trailing checksum beat via INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter logic [31:0] HALT_W = 32'hD800_0000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [AW-1:0] fetch_addr,
  output logic [31:0]   fetch_inst,
  output logic          proc_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StInit, StLoadHi, StLoadLo, StCheck, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StInit, StLoadHi, StLoadLo, StDone, StErr} state_e;
`endif

  state_e            state_q, state_d;
  logic [15:0]       hi_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW:0]       word_count_q;
  logic [DEPTH-1:0]  valid_q;
  logic              proc_hold_q, load_done_q, load_err_q;
  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic              wr_en;
  logic              ptr_at_end;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [15:0]       sum_q;
`endif

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StLoadHi, StLoadLo: in_ready = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      StCheck:            in_ready = 1'b1;
`endif
      default:            in_ready = 1'b0;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign wr_en      = accept & (state_q == StLoadLo) & ~reset;
  assign ptr_at_end = (wr_ptr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: state_d = StLoadHi;
      StLoadHi: begin
        // A final beat landing on a high half means an odd halfword count.
        if (accept) state_d = in_last ? StErr : StLoadLo;
      end
      StLoadLo: begin
        if (accept) begin
          if (in_last) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else if (ptr_at_end) begin
            state_d = StErr;
          end else begin
            state_d = StLoadHi;
          end
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) state_d = (in_data == sum_q) ? StDone : StErr;
      end
`endif
      StDone:  state_d = StDone;
      StErr:   state_d = StErr;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StInit;
      hi_q         <= '0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      valid_q      <= '0;
      proc_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      proc_hold_q <= (state_d != StDone);
      load_done_q <= (state_d == StDone);
      load_err_q  <= (state_d == StErr);
      if (accept && state_q == StLoadHi) hi_q <= in_data;
      if (wr_en) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        word_count_q      <= word_count_q + 1'b1;
      end
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= '0;
    end else if (accept && (state_q == StLoadHi || state_q == StLoadLo)) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

  // Storage is deliberately not reset; the valid bitmap masks stale entries.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= {hi_q, in_data};
  end

  assign fetch_inst = valid_q[fetch_addr] ? mem[fetch_addr] : HALT_W;
  assign proc_hold  = proc_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed and randomized streams against a stream-level model.
module tb_inst_loader;

  localparam logic [31:0] Halt = 32'hD800_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  fetch_addr = '0;
  logic [31:0] fetch_inst;
  logic        proc_hold, load_done, load_err;
  logic [4:0]  word_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] stream[$];

  always #5 clock = ~clock;

  inst_loader dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .fetch_addr (fetch_addr),
    .fetch_inst (fetch_inst),
    .proc_hold  (proc_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input int addr, input logic [31:0] exp);
    fetch_addr = 4'(addr);
    #1;
    check_val(tag, fetch_inst, exp);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l, input int gap);
    int n;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      in_data = 16'($urandom);
      in_last = 1'($urandom);
      @(posedge clock);
      #1;
    end
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!in_ready) check_val("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Reset, push `stream` and compare the outcome with what the stream rules predict.
  task automatic run_load(input int lastpos, input int max_gap, input logic bad_sum);
    int          nbeats, words;
    logic        exp_done;
    logic [15:0] sum;
    logic [31:0] exp_mem [16];

    if (lastpos < 0) begin
      nbeats   = 32;
      words    = 16;
      exp_done = 1'b0;
    end else begin
      nbeats   = lastpos + 1;
      words    = nbeats / 2;
      exp_done = (nbeats % 2) == 0;
    end
    for (int a = 0; a < 16; a++)
      exp_mem[a] = (a < words) ? {stream[2*a], stream[2*a+1]} : Halt;

    do_reset();
    check_val("rst_ready", 32'(in_ready), 32'd0);
    check_val("rst_hold", 32'(proc_hold), 32'd1);
    check_val("rst_done", 32'(load_done), 32'd0);
    check_val("rst_err", 32'(load_err), 32'd0);
    check_val("rst_wc", 32'(word_count), 32'd0);
    check_fetch("rst_fetch0", 0, Halt);

    sum = '0;
    for (int i = 0; i < nbeats; i++) begin
      sum += stream[i];
      send_beat(stream[i], (i == lastpos), $urandom_range(max_gap, 0));
      if (i != nbeats - 1) begin
        check_val("mid_wc", 32'(word_count), 32'((i + 1) / 2));
        check_val("mid_hold", 32'(proc_hold), 32'd1);
        check_val("mid_err", 32'(load_err), 32'd0);
      end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    if (exp_done) begin
      check_val("chk_hold", 32'(proc_hold), 32'd1);
      check_val("chk_ready", 32'(in_ready), 32'd1);
      send_beat(bad_sum ? sum + 16'd1 : sum, 1'($urandom), $urandom_range(max_gap, 0));
      exp_done = !bad_sum;
    end
`else
    if (bad_sum) sum = '0;
`endif

    check_val("end_done", 32'(load_done), 32'(exp_done));
    check_val("end_err", 32'(load_err), 32'(!exp_done));
    check_val("end_hold", 32'(proc_hold), 32'(!exp_done));
    check_val("end_ready", 32'(in_ready), 32'd0);
    check_val("end_wc", 32'(word_count), 32'(words));
    for (int a = 0; a < 16; a++) check_fetch($sformatf("fetch%0d", a), a, exp_mem[a]);

    // Terminal states must ignore further offered beats.
    in_data  = 16'($urandom);
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1 in_valid = 1'b0;
    check_val("term_wc", 32'(word_count), 32'(words));
    check_val("term_done", 32'(load_done), 32'(exp_done));
  endtask

  initial begin
    int lp, len;

    // Reference program, back-to-back then with random gaps.
    stream = '{16'h0840, 16'h0005, 16'h0880, 16'h0007};
    run_load(3, 0, 1'b0);
    check_fetch("dir_fetch0", 0, 32'h0840_0005);
    check_fetch("dir_fetch1", 1, 32'h0880_0007);
    check_fetch("dir_fetch2", 2, Halt);
    run_load(3, 5, 1'b0);

    // Odd halfword count.
    stream = '{16'h1111, 16'h2222, 16'h3333};
    run_load(2, 2, 1'b0);

    // Overflow: 32 halfwords without in_last.
    stream = {};
    for (int i = 0; i < 32; i++) stream.push_back(16'($urandom));
    run_load(-1, 1, 1'b0);

    // Reset mid-load, then a one-word reload.
    do_reset();
    send_beat(16'h1234, 1'b0, 0);
    send_beat(16'h5678, 1'b0, 0);
    send_beat(16'h9abc, 1'b0, 0);
    stream = '{16'hD800, 16'h0000};
    run_load(1, 0, 1'b0);
    check_fetch("reload_fetch1", 1, Halt);

`ifdef INST_LOADER_CHECKSUM_EN
    stream = '{16'h0001, 16'h0002};
    run_load(1, 0, 1'b0);
    run_load(1, 0, 1'b1);
`endif

    for (int it = 0; it < 25; it++) begin
      lp = int'($urandom_range(32, 0));
      if (lp == 32) lp = -1;
      len = (lp < 0) ? 32 : lp + 1;
      stream = {};
      for (int i = 0; i < len; i++) stream.push_back(16'($urandom));
      run_load(lp, 5, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
